// File: rtl/unary_add_mod_n.sv
// Unary accumulator modulo MOD over N_IN unary lanes, with add/subtract read phase,
// saturating wrap tally, and a write phase that drains the count as a unary pulse train.
module unary_add_mod_n #(
    parameter int unsigned N_IN    = 2,
    parameter int unsigned MOD     = 12,
    parameter int unsigned CARRY_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     read_or_write,
    input  logic                     sub,
    input  logic [N_IN-1:0]          din,
    output logic                     dout,
    output logic                     C,
    output logic [CARRY_W-1:0]       carry_cnt,
    output logic [$clog2(MOD)-1:0]   count,
    output logic                     done
);

    localparam int unsigned          CW       = $clog2(MOD);
    localparam logic [CW:0]          ModW     = (CW + 1)'(MOD);
    localparam logic [CARRY_W-1:0]   CarryMax = '1;

    // N_IN <= MOD guarantees at most one wrap per cycle.
    if (N_IN < 1 || N_IN > MOD || MOD < 2) begin : g_param_check
        $error("unary_add_mod_n: need MOD >= 2 and 1 <= N_IN <= MOD");
    end

    logic [CW-1:0]      count_q, count_d;
    logic [CARRY_W-1:0] carry_q, carry_d;
    logic               dout_q, dout_d;
    logic               c_q, c_d;
    logic               done_q, done_d;

    logic [CW:0]        s;
    logic [CW:0]        t_add;
    logic [CW:0]        t_borrow;
    logic               wrap;

    always_comb begin
        s = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            s = s + {{CW{1'b0}}, din[i]};
        end
    end

    always_comb begin
        count_d  = count_q;
        carry_d  = carry_q;
        dout_d   = dout_q;
        c_d      = c_q;
        done_d   = done_q;
        wrap     = 1'b0;
        t_add    = {1'b0, count_q} + s;
        t_borrow = {1'b0, count_q} + ModW - s;

        if (!read_or_write) begin
            dout_d = 1'b0;
            done_d = 1'b0;
            if (!sub) begin
                if (t_add >= ModW) begin
                    count_d = CW'(t_add - ModW);
                    wrap    = 1'b1;
                end else begin
                    count_d = CW'(t_add);
                end
            end else begin
                if ({1'b0, count_q} >= s) begin
                    count_d = CW'({1'b0, count_q} - s);
                end else begin
                    count_d = CW'(t_borrow);
                    wrap    = 1'b1;
                end
            end
            c_d = wrap;
            if (wrap && (carry_q != CarryMax)) begin
                carry_d = carry_q + 1'b1;
            end
        end else begin
            c_d = 1'b0;
            if (count_q != '0) begin
                dout_d  = 1'b1;
                count_d = count_q - 1'b1;
                done_d  = 1'b0;
            end else begin
                dout_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_q <= '0;
            carry_q <= '0;
            dout_q  <= 1'b0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
        end else if (en) begin
            count_q <= count_d;
            carry_q <= carry_d;
            dout_q  <= dout_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

    assign count     = count_q;
    assign carry_cnt = carry_q;
    assign dout      = dout_q;
    assign C         = c_q;
    assign done      = done_q;

endmodule

// File: tb/tb_unary_add_mod_n.sv
// Bench for unary_add_mod_n: default instance (MOD=12, N_IN=2) and a small one
// (MOD=5, N_IN=4, CARRY_W=2), both checked every cycle against an arithmetic model.
module tb_unary_add_mod_n;

    logic       clk;
    logic       rst_n, en, clr, rw, sub;
    logic [1:0] din0;
    logic [3:0] din1;

    logic       d0_dout, d0_c, d0_done;
    logic [3:0] d0_carry;
    logic [3:0] d0_count;
    logic       d1_dout, d1_c, d1_done;
    logic [1:0] d1_carry;
    logic [2:0] d1_count;

    int total = 0;
    int bad   = 0;

    unary_add_mod_n #(.N_IN(2), .MOD(12), .CARRY_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .read_or_write(rw), .sub(sub),
        .din(din0), .dout(d0_dout), .C(d0_c), .carry_cnt(d0_carry), .count(d0_count),
        .done(d0_done)
    );

    unary_add_mod_n #(.N_IN(4), .MOD(5), .CARRY_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .read_or_write(rw), .sub(sub),
        .din(din1), .dout(d1_dout), .C(d1_c), .carry_cnt(d1_carry), .count(d1_count),
        .done(d1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int car;
        bit c;
        bit d;
        bit dn;
    } mst_t;

    mst_t m0, m1;
    bit   armed = 1'b0;

    function automatic mst_t nxt(mst_t m, int mod, int cmax, bit rn, bit cl, bit e,
                                 bit w, bit sb, int s);
        mst_t r;
        int   t;
        r = m;
        if (!rn || cl) begin
            r.cnt = 0; r.car = 0; r.c = 0; r.d = 0; r.dn = 0;
        end else if (e) begin
            if (!w) begin
                r.d  = 0;
                r.dn = 0;
                t    = sb ? m.cnt - s : m.cnt + s;
                r.c  = (t < 0) || (t >= mod);
                r.cnt = (t + mod) % mod;
                if (r.c && r.car < cmax) r.car = r.car + 1;
            end else begin
                r.c  = 0;
                r.d  = (m.cnt > 0);
                r.dn = (m.cnt == 0);
                if (m.cnt > 0) r.cnt = m.cnt - 1;
            end
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m0 <= nxt(m0, 12, 15, rst_n, clr, en, rw, sub, $countones(din0));
        m1 <= nxt(m1, 5, 3, rst_n, clr, en, rw, sub, $countones(din1));
        if (!rst_n) armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            check("d0_count", 32'(d0_count), 32'(m0.cnt));
            check("d0_carry", 32'(d0_carry), 32'(m0.car));
            check("d0_C",     32'(d0_c),     32'(m0.c));
            check("d0_dout",  32'(d0_dout),  32'(m0.d));
            check("d0_done",  32'(d0_done),  32'(m0.dn));
            check("d1_count", 32'(d1_count), 32'(m1.cnt));
            check("d1_carry", 32'(d1_carry), 32'(m1.car));
            check("d1_C",     32'(d1_c),     32'(m1.c));
            check("d1_dout",  32'(d1_dout),  32'(m1.d));
            check("d1_done",  32'(d1_done),  32'(m1.dn));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive0(input logic [1:0] d, input int n);
        din0 = d;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; rw = 1'b0; sub = 1'b0;
        din0 = '0; din1 = '0;
        step();
        step();
        check("rst_count", 32'(d0_count), 0);
        check("rst_carry", 32'(d0_carry), 0);
        check("rst_done",  32'(d0_done),  0);
        check("rst_dout",  32'(d0_dout),  0);
        rst_n = 1'b1;

        // T1: 11 + 2 wraps to 1
        drive0(2'b11, 5);
        drive0(2'b01, 1);
        check("t1_pre_count", 32'(d0_count), 11);
        drive0(2'b11, 1);
        check("t1_count", 32'(d0_count), 1);
        check("t1_C",     32'(d0_c),     1);
        check("t1_carry", 32'(d0_carry), 1);
        drive0(2'b00, 1);
        check("t1_C_clr",   32'(d0_c),     0);
        check("t1_count_h", 32'(d0_count), 1);

        // T2: exact wrap to 0
        drive0(2'b11, 4);
        drive0(2'b01, 1);
        check("t2_pre_count", 32'(d0_count), 10);
        drive0(2'b11, 1);
        check("t2a_count", 32'(d0_count), 0);
        check("t2a_C",     32'(d0_c),     1);
        drive0(2'b11, 5);
        drive0(2'b01, 1);
        drive0(2'b01, 1);
        check("t2b_count", 32'(d0_count), 0);
        check("t2b_C",     32'(d0_c),     1);
        check("t2b_carry", 32'(d0_carry), 3);

        // T3: borrow, then plain subtract
        sub = 1'b1;
        drive0(2'b11, 1);
        check("t3a_count", 32'(d0_count), 10);
        check("t3a_C",     32'(d0_c),     1);
        check("t3a_carry", 32'(d0_carry), 4);
        sub = 1'b0;
        drive0(2'b11, 2);
        drive0(2'b01, 1);
        sub = 1'b1;
        drive0(2'b10, 1);
        check("t3b_count", 32'(d0_count), 2);
        check("t3b_C",     32'(d0_c),     0);
        check("t3b_carry", 32'(d0_carry), 5);

        // T4: drain 3 units
        sub = 1'b0;
        drive0(2'b01, 1);
        rw = 1'b1; din0 = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_dout",  32'(d0_dout),  1);
            check("t4_count", 32'(d0_count), 32'(2 - i));
            check("t4_done",  32'(d0_done),  0);
        end
        step();
        check("t4_dout_end", 32'(d0_dout),  0);
        check("t4_done_end", 32'(d0_done),  1);
        check("t4_count_0",  32'(d0_count), 0);
        step();
        check("t4_done_hold", 32'(d0_done), 1);

        // T5: freeze mid-drain, then reset mid-drain
        rw = 1'b0;
        drive0(2'b11, 2);
        drive0(2'b01, 1);
        rw = 1'b1;
        step();
        step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din0 = 2'(i);
            din1 = 4'(i * 3);
            sub  = i[0];
            step();
            check("t5_count", 32'(d0_count), 3);
            check("t5_dout",  32'(d0_dout),  1);
            check("t5_done",  32'(d0_done),  0);
            check("t5_carry", 32'(d0_carry), 5);
        end
        en = 1'b1; rst_n = 1'b0; sub = 1'b0; din0 = '0; din1 = '0;
        step();
        check("t5_rst_count", 32'(d0_count), 0);
        check("t5_rst_dout",  32'(d0_dout),  0);
        check("t5_rst_carry", 32'(d0_carry), 0);
        rst_n = 1'b1;

        // T6: saturate the 2-bit tally on the small instance, then clear with en low
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t6_clr_carry", 32'(d1_carry), 0);
        rw = 1'b0; din1 = 4'hF;
        for (int i = 0; i < 7; i++) step();
        check("t6_sat_carry", 32'(d1_carry), 3);
        check("t6_sat_count", 32'(d1_count), 3);
        din1 = '0; en = 1'b0; clr = 1'b1;
        step();
        check("t6_clr2_carry", 32'(d1_carry), 0);
        check("t6_clr2_count", 32'(d1_count), 0);
        clr = 1'b0; en = 1'b1;

        // Random sweep against the model
        for (int i = 0; i < 600; i++) begin
            din0  = 2'($urandom);
            din1  = 4'($urandom);
            sub   = 1'($urandom);
            if ($urandom_range(7) == 0) rw = ~rw;
            en    = ($urandom_range(7) != 0);
            clr   = ($urandom_range(63) == 0);
            rst_n = ($urandom_range(127) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
